// File: rtl/div_38by20_pkg.sv
// Shared definitions for the 38-by-20 restoring divider: widths, counter
// width and FSM state encodings.
package div_38by20_pkg;

  localparam int DIV_DW = 38;
  localparam int DIV_VW = 20;
  localparam int DIV_CW = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_38by20_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import div_38by20_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW-1:0] r,
  input  logic          in_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] r_next,
  output logic          q_bit
);

  // r' carries one extra bit so the compare sees the full shifted value.
  // Both outcomes are smaller than divisor, so the low VW bits of the
  // modular subtraction are the exact new remainder.
  logic [VW:0] r_sh;

  // Shift, compare, conditionally subtract.
  always_comb begin
    r_sh   = {r, in_bit};
    q_bit  = (r_sh >= {1'b0, divisor});
    r_next = q_bit ? (r_sh[VW-1:0] - divisor) : r_sh[VW-1:0];
  end

endmodule

// File: rtl/div_38by20.sv
// Sequential unsigned divider, DW-bit dividend by VW-bit divisor, one
// quotient bit per cycle (radix-2 restoring).
// Optional feature: define DIV_ROUND_EN for round-half-up quotients.
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// a result is released on a rising edge where out_valid && out_ready.
// in_valid is ignored whenever in_ready is low, and the result outputs stay
// frozen while out_valid is high and out_ready is low.
module div_38by20
  import div_38by20_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int            CW       = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_CALC  = S_CALC;
`ifdef DIV_ROUND_EN
  localparam logic [1:0] ST_ROUND = S_ROUND;
`endif
  localparam logic [1:0] ST_DONE  = S_DONE;

  // state is the FSM register (encodings of div_state_e).
  logic [1:0]    state;
  // Low through reset and for the first edge, so in_ready stays low in reset.
  logic          started;
  // Dividend bits leave at the top while quotient bits enter at the bottom;
  // after DW steps this register holds the whole quotient.
  logic [DW-1:0] dvd_sr;
  logic [VW-1:0] dvs_r;
  // Partial remainder; always below the divisor, so VW bits hold it.
  logic [VW-1:0] rem_r;
  logic [CW-1:0] cnt;
  // Zero divisor spends one CALC cycle so its result appears after E+1.
  logic          zero_r;

  logic [VW-1:0] step_r;
  logic          step_q;
  logic [DW-1:0] quo_next;

  div_step #(.VW(VW)) u_step (
    .r      (rem_r),
    .in_bit (dvd_sr[DW-1]),
    .divisor(dvs_r),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  assign quo_next  = {dvd_sr[DW-2:0], step_q};
  assign in_ready  = started && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      started   <= 1'b0;
      dvd_sr    <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      cnt       <= '0;
      zero_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            dvd_sr <= dividend;
            dvs_r  <= divisor;
            rem_r  <= '0;
            zero_r <= (divisor == '0);
            cnt    <= (divisor == '0) ? '0 : CNT_LAST;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (zero_r) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            state     <= ST_DONE;
          end else begin
            dvd_sr <= quo_next;
            rem_r  <= step_r;
            if (cnt == '0) begin
`ifdef DIV_ROUND_EN
              state <= ST_ROUND;
`else
              quotient  <= quo_next;
              remainder <= step_r;
              div_zero  <= 1'b0;
              state     <= ST_DONE;
`endif
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
`ifdef DIV_ROUND_EN
        ST_ROUND: begin
          // 2r >= d means the fraction is at least one half: round up.
          // A nonzero r implies d >= 2, so the increment cannot wrap.
          if ({rem_r, 1'b0} >= {1'b0, dvs_r}) begin
            quotient  <= dvd_sr + DW'(1);
            remainder <= '0;
          end else begin
            quotient  <= dvd_sr;
            remainder <= rem_r;
          end
          div_zero <= 1'b0;
          state    <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            div_zero <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
